ahb_lite_master: RTL

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_lite_master.sv | 101 ++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-master bridge: turns a valid/ready command stream into
// pipelined NONSEQ transfers and returns one in-order response per transfer.
module ahb_lite_master (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata,
  output logic        hsel,
  output logic [3:0]  haddr,
  output logic [1:0]  hsize,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] hwdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

  logic              vld_p0, vld_p1, cancel;
  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        size_p0;
  logic              write_p0, write_p1;
  logic [DATA_W-1:0] wdata_p0, wdata_p1;
  logic              adv, accept, done, nonseq;

  assign cmd_ready = (!vld_p0 && !vld_p1) || (hready && !hresp);
  assign adv       = cmd_ready;
  assign accept    = adv && cmd_valid;
  // An error's second cycle retires the data stage even though the pipe is frozen.
  assign done      = vld_p1 && hready;
  assign nonseq    = vld_p0 && !cancel;

  // Control: stage valid flags and error cancellation
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      cancel <= 1'b0;
    end else begin
      if (adv) begin
        vld_p1 <= vld_p0;
        vld_p0 <= cmd_valid;
      end else if (done) begin
        vld_p1 <= 1'b0;
      end
      if (vld_p1 && hresp && !hready)
        cancel <= 1'b1;
      else if (hready)
        cancel <= 1'b0;
    end
  end

  // Stage p0 (address) and p1 (data) payload; qualified by the valid flags
  always_ff @(posedge clk) begin
    if (adv) begin
      write_p1 <= write_p0;
      wdata_p1 <= wdata_p0;
    end
    if (accept) begin
      addr_p0  <= cmd_addr;
      size_p0  <= cmd_size;
      write_p0 <= cmd_write;
      wdata_p0 <= cmd_wdata;
    end
  end

  // Response stage: registered at the data-phase completion edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      rsp_error <= done && hresp;
      if (done)
        rsp_rdata <= write_p1 ? '0 : hrdata;
    end
  end

  assign htrans = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr  = nonseq ? addr_p0 : '0;
  assign hsize  = nonseq ? size_p0 : 2'd0;
  assign hwrite = nonseq && write_p0;
  assign hwdata = (vld_p1 && write_p1) ? wdata_p1 : '0;
  assign busy   = vld_p0 || vld_p1;
  assign hsel   = busy;

endmodule
